// File: rtl/mem_bist_ctrl.sv
// mem_bist_ctrl -- march-style BIST sequencer for a single-port synchronous RAM.
//
// Each run has four phases:
//   1. Clear:           write 0 to every address.
//   2. Read back:       read every address and expect 0.
//   3. Pattern write:   write each address with its own value.
//   4. Read back:       read every address and expect the address value.
// Every read is scored against its expected value, and mismatches are counted.
// All outputs are registered.
//
// Optional feature: defining MEM_BIST_ERRLOG_EN adds o_fail_addr/o_fail_data.
// These ports capture the address and returned data of the first mismatch in a run.
//
// Ports
//   i_clk        clock; all state changes on the rising edge
//   i_rst        asynchronous active-high reset
//   i_start      run request, honoured only in IDLE
//   i_data_out   registered read data from the memory (valid one cycle after o_read)
//   o_read       memory read strobe
//   o_write      memory write strobe
//   o_addr       memory address
//   o_data_in    memory write data
//   o_busy       run in progress (start-accept edge until DONE)
//   o_done       one-cycle completion pulse
//   o_pass       result, valid from o_done until the next accepted start
//   o_err_cnt    mismatching reads in the current run (saturating)
//   o_fail_addr  (MEM_BIST_ERRLOG_EN) address of first mismatch
//   o_fail_data  (MEM_BIST_ERRLOG_EN) data returned at first mismatch
//
// state    | meaning
// ---------+-------------------------------------------------------
// S_IDLE   | waiting for i_start
// S_CLR_WR | write 0 to every address, ascending
// S_CLR_RD | read every address, then one drain cycle; expect 0
// S_PAT_WR | write the address value to every address, ascending
// S_PAT_RD | read every address, then one drain cycle; expect address
// S_DONE   | one cycle: o_done pulses, o_pass is loaded

module mem_bist_ctrl #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_data_out,
    output logic              o_read,
    output logic              o_write,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_data_in,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_pass,
`ifdef MEM_BIST_ERRLOG_EN
    output logic [ADDR_W-1:0] o_fail_addr,
    output logic [DATA_W-1:0] o_fail_data,
`endif
    output logic [ADDR_W+1:0] o_err_cnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLR_WR, S_CLR_RD, S_PAT_WR, S_PAT_RD, S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [ADDR_W+1:0] ERR_MAX  = '1;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic                r_drain;
    logic                w_drain_nxt;
    logic                w_accept;
    logic                r_read;
    logic                r_write;
    logic [DATA_W-1:0]   r_data_in;
    logic                r_busy;
    logic                r_done;
    logic                r_pass;
    logic [ADDR_W+1:0]   r_err;
    logic [ADDR_W+1:0]   w_err_nxt;
    // The memory answers one cycle after the strobe.
    // These registers carry the read's expectation forward, so it lines up with i_data_out.
    logic                r_rd_d1;
    logic [DATA_W-1:0]   r_exp_d1;
    logic                w_cmp_fail;

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_drain_nxt = r_drain;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = S_CLR_WR;
                    w_addr_nxt  = '0;
                    w_drain_nxt = 1'b0;
                    w_accept    = 1'b1;
                end
            end
            S_CLR_WR, S_PAT_WR: begin
                if (r_addr == ADDR_MAX) begin
                    w_state_nxt = (r_state == S_CLR_WR) ? S_CLR_RD : S_PAT_RD;
                    w_addr_nxt  = '0;
                end else begin
                    w_addr_nxt = r_addr + ADDR_W'(1);
                end
            end
            S_CLR_RD, S_PAT_RD: begin
                if (r_drain) begin
                    w_state_nxt = (r_state == S_CLR_RD) ? S_PAT_WR : S_DONE;
                    w_drain_nxt = 1'b0;
                    w_addr_nxt  = '0;
                end else if (r_addr == ADDR_MAX) begin
                    w_drain_nxt = 1'b1;
                    w_addr_nxt  = '0;
                end else begin
                    w_addr_nxt = r_addr + ADDR_W'(1);
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Case inequality, so that X/Z returned by the memory in simulation counts as a failure.
    assign w_cmp_fail = r_rd_d1 && (i_data_out !== r_exp_d1);

    always_comb begin
        w_err_nxt = r_err;
        if (w_accept) begin
            w_err_nxt = '0;
        end else if (w_cmp_fail && (r_err != ERR_MAX)) begin
            w_err_nxt = r_err + (ADDR_W+2)'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_drain   <= 1'b0;
            r_read    <= 1'b0;
            r_write   <= 1'b0;
            r_data_in <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_err     <= '0;
            r_rd_d1   <= 1'b0;
            r_exp_d1  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_addr    <= w_addr_nxt;
            r_drain   <= w_drain_nxt;
            r_write   <= (w_state_nxt == S_CLR_WR) || (w_state_nxt == S_PAT_WR);
            r_read    <= ((w_state_nxt == S_CLR_RD) || (w_state_nxt == S_PAT_RD)) && !w_drain_nxt;
            r_data_in <= (w_state_nxt == S_PAT_WR) ? DATA_W'(w_addr_nxt) : '0;
            r_busy    <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
            r_done    <= (w_state_nxt == S_DONE);
            r_err     <= w_err_nxt;
            r_rd_d1   <= r_read;
            r_exp_d1  <= (r_state == S_PAT_RD) ? DATA_W'(r_addr) : '0;
            // The last read is scored on the same edge that enters DONE.
            // The pass decision therefore uses the updated count.
            if (w_accept) begin
                r_pass <= 1'b0;
            end else if (w_state_nxt == S_DONE) begin
                r_pass <= (w_err_nxt == '0);
            end
        end
    end

`ifdef MEM_BIST_ERRLOG_EN
    logic [ADDR_W-1:0] r_addr_d1;
    logic [ADDR_W-1:0] r_fail_addr;
    logic [DATA_W-1:0] r_fail_data;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_addr_d1   <= '0;
            r_fail_addr <= '0;
            r_fail_data <= '0;
        end else begin
            r_addr_d1 <= r_addr;
            if (w_accept) begin
                r_fail_addr <= '0;
                r_fail_data <= '0;
            end else if (w_cmp_fail && (r_err == '0)) begin
                r_fail_addr <= r_addr_d1;
                r_fail_data <= i_data_out;
            end
        end
    end

    assign o_fail_addr = r_fail_addr;
    assign o_fail_data = r_fail_data;
`endif

    assign o_read    = r_read;
    assign o_write   = r_write;
    assign o_addr    = r_addr;
    assign o_data_in = r_data_in;
    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_pass    = r_pass;
    assign o_err_cnt = r_err;

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Directed bench for mem_bist_ctrl.
// A 32x8 registered-read memory model can inject several faults:
//   - a stuck bit,
//   - address aliasing,
//   - an X on one read.
// Expected results are worked out by hand for each fault.
module tb_mem_bist_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] data_out;
    logic       read;
    logic       write;
    logic [4:0] addr;
    logic [7:0] data_in;
    logic       busy;
    logic       done;
    logic       pass;
    logic [6:0] err_cnt;
`ifdef MEM_BIST_ERRLOG_EN
    logic [4:0] fail_addr;
    logic [7:0] fail_data;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    int fault  = 0;
    int overlap_cnt = 0;
    int idle_strobe_cnt = 0;
    logic [7:0] mem [32];

    mem_bist_ctrl #(.ADDR_W(5), .DATA_W(8)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .i_data_out (data_out),
        .o_read     (read),
        .o_write    (write),
        .o_addr     (addr),
        .o_data_in  (data_in),
        .o_busy     (busy),
        .o_done     (done),
        .o_pass     (pass),
`ifdef MEM_BIST_ERRLOG_EN
        .o_fail_addr(fail_addr),
        .o_fail_data(fail_data),
`endif
        .o_err_cnt  (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fault modes:
    //   1: bit 0 of address 5 is stuck at 1.
    //   2: address bit 4 is ignored.
    //   3: X is returned when address 7 holds 7 (pattern phase only).
    always @(posedge clk) begin
        logic [4:0] ea;
        logic [7:0] d;
        ea = (fault == 2) ? (addr & 5'h0f) : addr;
        if (write) mem[ea] <= data_in;
        if (read) begin
            d = mem[ea];
            if (fault == 1 && addr == 5'd5) d = d | 8'h01;
            if (fault == 3 && addr == 5'd7 && mem[ea] == 8'd7) d = 8'hxx;
            data_out <= d;
        end
    end

    always @(negedge clk) begin
        if (read && write) overlap_cnt <= overlap_cnt + 1;
        if (!busy && (read || write)) idle_strobe_cnt <= idle_strobe_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic run_test(input string tag, input int exp_err, input logic exp_pass,
                            input int repulse, input logic [4:0] exp_fa,
                            input logic [7:0] exp_fd, input logic chk_fd);
        int cyc;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({tag, "_busy_on"}, 32'(busy), 32'd1);
        chk({tag, "_err_clr"}, 32'(err_cnt), 32'd0);
        cyc = 0;
        while (cyc < 300 && !done) begin
            @(posedge clk);
            #1;
            cyc++;
            start = (cyc == repulse);
        end
        start = 1'b0;
        chk({tag, "_done_cyc"}, 32'(cyc), 32'd130);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy_off"}, 32'(busy), 32'd0);
        chk({tag, "_err_cnt"}, 32'(err_cnt), 32'(exp_err));
        chk({tag, "_pass"}, 32'(pass), 32'(exp_pass));
`ifdef MEM_BIST_ERRLOG_EN
        chk({tag, "_fail_addr"}, 32'(fail_addr), 32'(exp_fa));
        if (chk_fd) chk({tag, "_fail_data"}, 32'(fail_data), 32'(exp_fd));
`else
        if (chk_fd && exp_fa == 5'd31 && exp_fd == 8'hff) n_chk = n_chk + 0;
`endif
        @(posedge clk);
        #1;
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_pass_hold"}, 32'(pass), 32'(exp_pass));
        chk({tag, "_err_hold"}, 32'(err_cnt), 32'(exp_err));
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 8'ha5;
        data_out = 8'h00;
        start = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_read", 32'(read), 32'd0);
        chk("rst_write", 32'(write), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_err", 32'(err_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        fault = 0;
        run_test("clean", 0, 1'b1, -1, 5'd0, 8'h00, 1'b1);
        fault = 1;
        run_test("stuck", 1, 1'b0, -1, 5'd5, 8'h01, 1'b1);
        fault = 2;
        run_test("alias", 16, 1'b0, -1, 5'd0, 8'h10, 1'b1);
        fault = 0;
        run_test("repulse", 0, 1'b1, 40, 5'd0, 8'h00, 1'b1);
        fault = 3;
        run_test("xinj", 1, 1'b0, -1, 5'd7, 8'h00, 1'b0);

        // Abort a run with reset between clock edges.
        fault = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (50) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("mid_rst_read", 32'(read), 32'd0);
        chk("mid_rst_write", 32'(write), 32'd0);
        chk("mid_rst_addr", 32'(addr), 32'd0);
        chk("mid_rst_data_in", 32'(data_in), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_pass", 32'(pass), 32'd0);
        chk("mid_rst_err", 32'(err_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_test("post_rst", 0, 1'b1, -1, 5'd0, 8'h00, 1'b1);

        chk("rw_overlap", 32'(overlap_cnt), 32'd0);
        chk("strobe_when_idle", 32'(idle_strobe_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
